store: RTL and testbench

STORE -- requirements
Module: store

---
 rtl/clangpu_pkg.sv | 21 ++
 rtl/store.sv | 164 ++++++++++++++++
 tb/tb_store.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clangpu_pkg.sv
// Shared definitions for the clangpu core: store FSM state encoding and
// AXI write-response codes, plus a helper that classifies error responses.
package clangpu_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_SEND = 2'b01,
      S_RESP = 2'b10
   } store_state_t;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   // SLVERR and DECERR both report a failed write; OKAY/EXOKAY are success.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
   endfunction

endpackage

// File: rtl/store.sv
// store: issues one single-beat AXI4 write per request and reports
// completion (O_DONE) and error status (O_ERR) back to the core.
// Optional feature macro: STORE_STRB_EN adds an I_STRB input that is latched
// with the data and driven onto WSTRB; without it WSTRB is all-ones.
module store
   import clangpu_pkg::*;
#(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32
)
(
   input  logic                              CLK,
   input  logic                              RST,
   output logic                              MEM_WAIT,
   input  logic                              I_VALID,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]     I_ADDR,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     I_DATA,
`ifdef STORE_STRB_EN
   input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   I_STRB,
`endif
   output logic                              O_DONE,
   output logic                              O_ERR,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic                              M_AXI_AWVALID,
   input  logic                              M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                              M_AXI_WLAST,
   output logic                              M_AXI_WVALID,
   input  logic                              M_AXI_WREADY,
   input  logic [1:0]                        M_AXI_BRESP,
   input  logic                              M_AXI_BVALID,
   output logic                              M_AXI_BREADY
);

   localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

   // Word-aligns the address: the two low byte-offset bits are dropped.
   localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ALIGN_MASK =
      {{(C_M_AXI_ADDR_WIDTH-2){1'b1}}, 2'b00};

   store_state_t                  state;
   store_state_t                  state_nxt;
   logic                          aw_done;
   logic                          w_done;
   logic                          awvalid_c;
   logic                          wvalid_c;
   logic                          bready_c;
   logic                          accept;
   logic                          b_hs;
   logic                          mem_wait_q;
   logic                          done_q;
   logic                          err_q;
   logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
   logic [C_M_AXI_DATA_WIDTH-1:0] data_q;

   assign accept = (state == S_IDLE) && I_VALID;
   assign b_hs   = bready_c && M_AXI_BVALID;

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: leave S_SEND only once both AW and W have handshaken,
   // counting a handshake that lands in the current cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (I_VALID) state_nxt = S_SEND;
         S_SEND: if ((aw_done || M_AXI_AWREADY) && (w_done || M_AXI_WREADY))
                    state_nxt = S_RESP;
         S_RESP: if (M_AXI_BVALID) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Channel valids/ready decoded from state; each valid drops for good
   // once its own handshake has been recorded.
   always_comb begin
      awvalid_c = 1'b0;
      wvalid_c  = 1'b0;
      bready_c  = 1'b0;
      case (state)
         S_SEND: begin
            awvalid_c = !aw_done;
            wvalid_c  = !w_done;
         end
         S_RESP:  bready_c = 1'b1;
         default: ;
      endcase
   end

   // Remember which of AW/W have completed; cleared while idle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else if (state == S_IDLE) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         if (awvalid_c && M_AXI_AWREADY) aw_done <= 1'b1;
         if (wvalid_c && M_AXI_WREADY)   w_done  <= 1'b1;
      end
   end

   // Capture the request on acceptance; held stable until back in idle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         addr_q <= '0;
         data_q <= '0;
      end else if (accept) begin
         addr_q <= I_ADDR & ALIGN_MASK;
         data_q <= I_DATA;
      end
   end

`ifdef STORE_STRB_EN
   logic [STRB_W-1:0] strb_q;

   // Byte strobes travel with the data.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         strb_q <= '0;
      end else if (accept) begin
         strb_q <= I_STRB;
      end
   end

   assign M_AXI_WSTRB = strb_q;
`else
   assign M_AXI_WSTRB = {STRB_W{1'b1}};
`endif

   // Busy flag and completion pulse, registered from the next state and
   // the B handshake so the caller sees them one cycle after the event.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         mem_wait_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         mem_wait_q <= (state_nxt != S_IDLE);
         done_q     <= b_hs;
         err_q      <= b_hs && resp_is_err(M_AXI_BRESP);
      end
   end

   assign MEM_WAIT      = mem_wait_q;
   assign O_DONE        = done_q;
   assign O_ERR         = err_q;
   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_AWVALID = awvalid_c;
   assign M_AXI_WDATA   = data_q;
   assign M_AXI_WVALID  = wvalid_c;
   assign M_AXI_WLAST   = wvalid_c;
   assign M_AXI_BREADY  = bready_c;

endmodule

// File: tb/tb_store.sv
// Scoreboard bench for store: a driver issues requests and pushes expected
// AW/W/B outcomes into queues; monitors pop and compare on each handshake.
module tb_store;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic          CLK;
   logic          RST;
   logic          MEM_WAIT;
   logic          I_VALID;
   logic [AW-1:0] I_ADDR;
   logic [DW-1:0] I_DATA;
`ifdef STORE_STRB_EN
   logic [SW-1:0] I_STRB;
`endif
   logic          O_DONE;
   logic          O_ERR;
   logic [AW-1:0] M_AXI_AWADDR;
   logic          M_AXI_AWVALID;
   logic          M_AXI_AWREADY;
   logic [DW-1:0] M_AXI_WDATA;
   logic [SW-1:0] M_AXI_WSTRB;
   logic          M_AXI_WLAST;
   logic          M_AXI_WVALID;
   logic          M_AXI_WREADY;
   logic [1:0]    M_AXI_BRESP;
   logic          M_AXI_BVALID;
   logic          M_AXI_BREADY;

   store #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW)) dut (
      .CLK(CLK), .RST(RST), .MEM_WAIT(MEM_WAIT),
      .I_VALID(I_VALID), .I_ADDR(I_ADDR), .I_DATA(I_DATA),
`ifdef STORE_STRB_EN
      .I_STRB(I_STRB),
`endif
      .O_DONE(O_DONE), .O_ERR(O_ERR),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID),
      .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
      .M_AXI_WLAST(M_AXI_WLAST), .M_AXI_WVALID(M_AXI_WVALID),
      .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
      .M_AXI_BREADY(M_AXI_BREADY)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int n_done  = 0;
   int n_aw_hs = 0;

   // Slave behaviour for the transaction in flight.
   int         aw_dly = 0;
   int         w_dly  = 0;
   int         b_dly  = 0;
   logic [1:0] cur_resp = 2'b00;

   // Scoreboard queues.
   logic [AW-1:0]    aw_q[$];
   logic [DW+SW-1:0] w_q[$];
   logic             err_q[$];

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
   endtask

   function automatic logic [SW-1:0] exp_strb(input logic [SW-1:0] s);
`ifdef STORE_STRB_EN
      return s;
`else
      return {SW{1'b1}} | s;
`endif
   endfunction

   // AW slave: raise AWREADY after aw_dly cycles of AWVALID.
   initial begin
      int cnt = 0;
      M_AXI_AWREADY = 1'b0;
      forever begin
         @(negedge CLK);
         if (M_AXI_AWVALID && !M_AXI_AWREADY) begin
            if (cnt >= aw_dly) M_AXI_AWREADY = 1'b1;
            else cnt++;
         end else begin
            M_AXI_AWREADY = 1'b0;
            cnt = 0;
         end
      end
   end

   // W slave.
   initial begin
      int cnt = 0;
      M_AXI_WREADY = 1'b0;
      forever begin
         @(negedge CLK);
         if (M_AXI_WVALID && !M_AXI_WREADY) begin
            if (cnt >= w_dly) M_AXI_WREADY = 1'b1;
            else cnt++;
         end else begin
            M_AXI_WREADY = 1'b0;
            cnt = 0;
         end
      end
   end

   // B slave.
   initial begin
      int cnt = 0;
      M_AXI_BVALID = 1'b0;
      M_AXI_BRESP  = 2'b00;
      forever begin
         @(negedge CLK);
         if (M_AXI_BREADY && !M_AXI_BVALID) begin
            if (cnt >= b_dly) begin
               M_AXI_BVALID = 1'b1;
               M_AXI_BRESP  = cur_resp;
            end else cnt++;
         end else begin
            M_AXI_BVALID = 1'b0;
            cnt = 0;
         end
      end
   end

   // Monitor: handshakes take effect on the following rising edge.
   initial begin
      forever begin
         @(negedge CLK);
         #2;
         if (!RST) begin
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
               n_aw_hs++;
               if (aw_q.size() == 0) fail_now("unexpected_aw");
               else chk("awaddr", 64'(M_AXI_AWADDR), 64'(aw_q.pop_front()));
            end
            if (M_AXI_WVALID && M_AXI_WREADY) begin
               if (w_q.size() == 0) fail_now("unexpected_w");
               else begin
                  logic [DW+SW-1:0] e;
                  e = w_q.pop_front();
                  chk("wdata", 64'(M_AXI_WDATA), 64'(e[DW+SW-1:SW]));
                  chk("wstrb", 64'(M_AXI_WSTRB), 64'(e[SW-1:0]));
                  chk("wlast", 64'(M_AXI_WLAST), 64'(1));
               end
            end
            if (O_DONE) begin
               n_done++;
               if (err_q.size() == 0) fail_now("unexpected_done");
               else chk("o_err", 64'(O_ERR), 64'(err_q.pop_front()));
            end else if (O_ERR) begin
               fail_now("o_err_without_done");
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge CLK);
      #1;
   endtask

   // Issue one request; returns at the falling edge of cycle 1.
   task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input logic [1:0] r,
                        input int ad, input int wd, input int bd);
      int n = 0;
      @(negedge CLK);
      while (MEM_WAIT !== 1'b0 && n < 200) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 200) fail_now("accept_timeout");
      aw_dly = ad; w_dly = wd; b_dly = bd; cur_resp = r;
      aw_q.push_back((a / 4) * 4);
      w_q.push_back({d, exp_strb(s)});
      err_q.push_back(r >= 2'd2);
      I_VALID = 1'b1;
      I_ADDR  = a;
      I_DATA  = d;
`ifdef STORE_STRB_EN
      I_STRB  = s;
`endif
      @(negedge CLK);
      I_VALID = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge CLK);
      while ((MEM_WAIT !== 1'b0 || err_q.size() != 0) && n < 500) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 500) fail_now("idle_timeout");
      step(1);
   endtask

   initial begin
      int base_done;
      int base_aw;
      int n;
      RST = 1'b1;
      I_VALID = 1'b0;
      I_ADDR = '0;
      I_DATA = '0;
`ifdef STORE_STRB_EN
      I_STRB = '0;
`endif
      step(2);
      chk("rst_mem_wait", 64'(MEM_WAIT), 64'(0));
      chk("rst_awvalid", 64'(M_AXI_AWVALID), 64'(0));
      chk("rst_wvalid", 64'(M_AXI_WVALID), 64'(0));
      chk("rst_bready", 64'(M_AXI_BREADY), 64'(0));
      chk("rst_awaddr", 64'(M_AXI_AWADDR), 64'(0));
      chk("rst_o_done", 64'(O_DONE), 64'(0));
      @(negedge CLK);
      RST = 1'b0;

      // Minimum-latency store with a misaligned address.
      issue(32'h1003, 32'hDEADBEEF, 4'hF, 2'b00, 0, 0, 0);
      #1;
      chk("c1_awvalid", 64'(M_AXI_AWVALID), 64'(1));
      chk("c1_wvalid", 64'(M_AXI_WVALID), 64'(1));
      chk("c1_wlast", 64'(M_AXI_WLAST), 64'(1));
      chk("c1_awaddr", 64'(M_AXI_AWADDR), 64'h1000);
      chk("c1_wdata", 64'(M_AXI_WDATA), 64'hDEADBEEF);
      chk("c1_mem_wait", 64'(MEM_WAIT), 64'(1));
      step(1);
      chk("c2_bready", 64'(M_AXI_BREADY), 64'(1));
      chk("c2_awvalid", 64'(M_AXI_AWVALID), 64'(0));
      step(1);
      chk("c3_o_done", 64'(O_DONE), 64'(1));
      chk("c3_o_err", 64'(O_ERR), 64'(0));
      chk("c3_mem_wait", 64'(MEM_WAIT), 64'(0));
      step(1);
      chk("c4_o_done", 64'(O_DONE), 64'(0));
      wait_idle();

      // AWREADY 4 cycles late, WREADY immediate.
      issue(32'h0000_4008, 32'hA5A5_0001, 4'hF, 2'b00, 4, 0, 0);
      #1;
      chk("dly_c1_awvalid", 64'(M_AXI_AWVALID), 64'(1));
      step(1);
      chk("dly_c2_wvalid", 64'(M_AXI_WVALID), 64'(0));
      chk("dly_c2_awvalid", 64'(M_AXI_AWVALID), 64'(1));
      step(3);
      chk("dly_c5_awvalid", 64'(M_AXI_AWVALID), 64'(1));
      chk("dly_c5_wvalid", 64'(M_AXI_WVALID), 64'(0));
      step(1);
      chk("dly_c6_awvalid", 64'(M_AXI_AWVALID), 64'(0));
      chk("dly_c6_bready", 64'(M_AXI_BREADY), 64'(1));
      step(1);
      chk("dly_c7_o_done", 64'(O_DONE), 64'(1));
      wait_idle();

      // SLVERR response.
      issue(32'h0000_0100, 32'h0BAD_F00D, 4'hF, 2'b10, 0, 0, 0);
      step(2);
      chk("err_o_done", 64'(O_DONE), 64'(1));
      chk("err_o_err", 64'(O_ERR), 64'(1));
      step(1);
      chk("err_o_done_pulse", 64'(O_DONE), 64'(0));
      chk("err_o_err_pulse", 64'(O_ERR), 64'(0));
      wait_idle();

      // Strobes.
      issue(32'h0000_0200, 32'h1122_3344, 4'b0011, 2'b00, 0, 0, 0);
      #1;
      chk("wstrb_c1", 64'(M_AXI_WSTRB), 64'(exp_strb(4'b0011)));
      wait_idle();

      // Second request held while busy: ignored until the first completes.
      base_aw = n_aw_hs;
      base_done = n_done;
      @(negedge CLK);
      aw_dly = 0; w_dly = 0; b_dly = 0; cur_resp = 2'b00;
      aw_q.push_back(32'h1004);
      w_q.push_back({32'h0000_0001, exp_strb(4'hF)});
      err_q.push_back(1'b0);
      I_VALID = 1'b1; I_ADDR = 32'h1004; I_DATA = 32'h0000_0001;
`ifdef STORE_STRB_EN
      I_STRB = 4'hF;
`endif
      @(negedge CLK);
      aw_q.push_back(32'h2000);
      w_q.push_back({32'h0000_0002, exp_strb(4'hF)});
      err_q.push_back(1'b0);
      I_ADDR = 32'h2000; I_DATA = 32'h0000_0002;
      n = 0;
      while (MEM_WAIT !== 1'b0 && n < 50) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 50) fail_now("hold_timeout");
      #3;
      chk("hold_first_done", 64'(n_done - base_done), 64'(1));
      @(negedge CLK);
      I_VALID = 1'b0;
      wait_idle();
      chk("hold_aw_count", 64'(n_aw_hs - base_aw), 64'(2));

      // Asynchronous reset while in S_SEND.
      base_done = n_done;
      issue(32'h0000_3000, 32'h1234_5678, 4'hF, 2'b00, 10, 10, 0);
      #1;
      chk("pre_rst_awvalid", 64'(M_AXI_AWVALID), 64'(1));
      RST = 1'b1;
      #1;
      chk("arst_mem_wait", 64'(MEM_WAIT), 64'(0));
      chk("arst_awvalid", 64'(M_AXI_AWVALID), 64'(0));
      chk("arst_wvalid", 64'(M_AXI_WVALID), 64'(0));
      chk("arst_wlast", 64'(M_AXI_WLAST), 64'(0));
      chk("arst_bready", 64'(M_AXI_BREADY), 64'(0));
      chk("arst_awaddr", 64'(M_AXI_AWADDR), 64'(0));
      chk("arst_wdata", 64'(M_AXI_WDATA), 64'(0));
      chk("arst_o_done", 64'(O_DONE), 64'(0));
      chk("arst_o_err", 64'(O_ERR), 64'(0));
      @(negedge CLK);
      @(negedge CLK);
      aw_q.delete();
      w_q.delete();
      err_q.delete();
      RST = 1'b0;
      step(4);
      chk("arst_no_done", 64'(n_done - base_done), 64'(0));
      issue(32'h0000_3004, 32'h8765_4321, 4'hF, 2'b00, 0, 0, 0);
      wait_idle();
      chk("post_rst_done", 64'(n_done - base_done), 64'(1));

      // Randomized traffic.
      for (int i = 0; i < 40; i++) begin
         issue($urandom, $urandom, 4'($urandom), 2'($urandom),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end
      wait_idle();
      chk("aw_q_drained", 64'(aw_q.size()), 64'(0));
      chk("w_q_drained", 64'(w_q.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
